// File: rtl/ra_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : ra_cfg_bank
// Purpose  : Shadow/active configuration bank with byte-enable writes, atomic
//            idle-gated commit, readback, sticky write lock and error pulse.
// Revision : 1.0
// ============================================================================
module ra_cfg_bank #(
    parameter int                       GENMODE = 0,
    parameter int                       NREGS   = 4,
    parameter int                       WIDTH   = 32,
    parameter logic [NREGS*WIDTH-1:0]   INIT    = '0,
    localparam int                      AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_wr,
    input  logic [AW-1:0]               cfg_addr,
    input  logic [WIDTH/8-1:0]          cfg_be,
    input  logic [WIDTH-1:0]            cfg_dat,
    input  logic                        cfg_rd,
    input  logic                        cfg_rd_shadow,
    output logic [WIDTH-1:0]            cfg_rdat,
    output logic                        cfg_rvld,
    input  logic                        cfg_commit,
    input  logic                        arr_idle,
    input  logic                        cfg_lock,
    output logic                        cfg_locked,
    output logic                        commit_pend,
    output logic                        cfg_err,
    output logic                        cfg_upd,
    output logic [NREGS*WIDTH-1:0]      cfg
);

    localparam int NBYTES = WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_lock;
    logic                   r_err;
    logic                   r_upd;
    logic                   r_rvld;
    logic [WIDTH-1:0]       r_rdat;
    logic [WIDTH-1:0]       r_shadow [NREGS];
    logic [WIDTH-1:0]       r_active [NREGS];

    logic                   w_addr_ok;
    logic                   w_wr_ok;
    logic                   w_wr_err;
    logic                   w_rd_err;
    logic                   w_cmt_err;
    logic                   w_xfer;
    logic [WIDTH-1:0]       w_rsel;
    logic [NREGS*WIDTH-1:0] w_active_flat;

    assign w_addr_ok = (32'(cfg_addr) < NREGS);
    assign w_wr_ok   = cfg_wr && w_addr_ok && !r_lock;
    assign w_wr_err  = cfg_wr && (!w_addr_ok || r_lock);
    assign w_rd_err  = cfg_rd && !w_addr_ok;
    assign w_cmt_err = (r_state == ST_IDLE) && cfg_commit && r_lock;

    // A pending commit completes on idle even if the lock was set meanwhile.
    assign w_xfer = (r_state == ST_IDLE) ? (cfg_commit && !r_lock && arr_idle)
                                         : arr_idle;

    assign w_rsel = cfg_rd_shadow ? r_shadow[cfg_addr] : r_active[cfg_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_lock <= r_lock | cfg_lock;
            r_err  <= w_wr_err | w_rd_err | w_cmt_err;
            r_upd  <= w_xfer;
            case (r_state)
                ST_IDLE: if (cfg_commit && !r_lock && !arr_idle) r_state <= ST_PEND;
                ST_PEND: if (arr_idle) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Transfer copies the pre-edge shadow, so a same-cycle write is excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_shadow[r] <= INIT[(NREGS-r)*WIDTH-1 -: WIDTH];
                r_active[r] <= INIT[(NREGS-r)*WIDTH-1 -: WIDTH];
            end
        end else begin
            if (w_wr_ok) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (cfg_be[b]) r_shadow[cfg_addr][8*b +: 8] <= cfg_dat[8*b +: 8];
                end
            end
            if (w_xfer) begin
                for (int r = 0; r < NREGS; r++) r_active[r] <= r_shadow[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvld <= 1'b0;
            r_rdat <= '0;
        end else begin
            r_rvld <= cfg_rd;
            if (cfg_rd) r_rdat <= w_addr_ok ? w_rsel : '0;
        end
    end

    generate
        for (genvar r = 0; r < NREGS; r++) begin : g_pack
            assign w_active_flat[(NREGS-r)*WIDTH-1 -: WIDTH] = r_active[r];
        end

        if (GENMODE == 0) begin : g_direct
            assign cfg     = w_active_flat;
            assign cfg_upd = r_upd;
        end else begin : g_staged
            logic [NREGS*WIDTH-1:0] r_cfg_q;
            logic                   r_upd_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cfg_q <= INIT;
                    r_upd_q <= 1'b0;
                end else begin
                    r_cfg_q <= w_active_flat;
                    r_upd_q <= r_upd;
                end
            end
            assign cfg     = r_cfg_q;
            assign cfg_upd = r_upd_q;
        end
    endgenerate

    assign cfg_rdat    = r_rdat;
    assign cfg_rvld    = r_rvld;
    assign cfg_err     = r_err;
    assign cfg_locked  = r_lock;
    assign commit_pend = (r_state == ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_ra_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ra_cfg_bank
// Purpose  : Directed checks of ra_cfg_bank in three configurations sharing
//            one stimulus stream (NREGS=4/GENMODE=0, NREGS=4/GENMODE=1, NREGS=3).
// Revision : 1.0
// ============================================================================
module tb_ra_cfg_bank;

    localparam logic [127:0] INIT4 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [95:0]  INIT3 = 96'h11111111_22222222_33333333;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_wr, cfg_rd, cfg_rd_shadow, cfg_commit, arr_idle, cfg_lock;
    logic [1:0]   cfg_addr;
    logic [3:0]   cfg_be;
    logic [31:0]  cfg_dat;

    logic [31:0]  a_rdat, b_rdat, c_rdat;
    logic         a_rvld, b_rvld, c_rvld;
    logic         a_locked, b_locked, c_locked;
    logic         a_pend, b_pend, c_pend;
    logic         a_err, b_err, c_err;
    logic         a_upd, b_upd, c_upd;
    logic [127:0] a_cfg, b_cfg;
    logic [95:0]  c_cfg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ra_cfg_bank #(.GENMODE(0), .NREGS(4), .WIDTH(32), .INIT(INIT4)) u_a (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_be(cfg_be),
        .cfg_dat(cfg_dat), .cfg_rd(cfg_rd), .cfg_rd_shadow(cfg_rd_shadow), .cfg_rdat(a_rdat),
        .cfg_rvld(a_rvld), .cfg_commit(cfg_commit), .arr_idle(arr_idle), .cfg_lock(cfg_lock),
        .cfg_locked(a_locked), .commit_pend(a_pend), .cfg_err(a_err), .cfg_upd(a_upd), .cfg(a_cfg));

    ra_cfg_bank #(.GENMODE(1), .NREGS(4), .WIDTH(32), .INIT(INIT4)) u_b (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_be(cfg_be),
        .cfg_dat(cfg_dat), .cfg_rd(cfg_rd), .cfg_rd_shadow(cfg_rd_shadow), .cfg_rdat(b_rdat),
        .cfg_rvld(b_rvld), .cfg_commit(cfg_commit), .arr_idle(arr_idle), .cfg_lock(cfg_lock),
        .cfg_locked(b_locked), .commit_pend(b_pend), .cfg_err(b_err), .cfg_upd(b_upd), .cfg(b_cfg));

    ra_cfg_bank #(.GENMODE(0), .NREGS(3), .WIDTH(32), .INIT(INIT3)) u_c (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_be(cfg_be),
        .cfg_dat(cfg_dat), .cfg_rd(cfg_rd), .cfg_rd_shadow(cfg_rd_shadow), .cfg_rdat(c_rdat),
        .cfg_rvld(c_rvld), .cfg_commit(cfg_commit), .arr_idle(arr_idle), .cfg_lock(cfg_lock),
        .cfg_locked(c_locked), .commit_pend(c_pend), .cfg_err(c_err), .cfg_upd(c_upd), .cfg(c_cfg));

    function automatic logic [31:0] reg4(input logic [127:0] v, input int r);
        return v[(4-r)*32-1 -: 32];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr = 0; cfg_rd = 0; cfg_rd_shadow = 0; cfg_commit = 0;
        cfg_lock = 0; cfg_addr = 0; cfg_be = 0; cfg_dat = 0;
    endtask

    initial begin
        idle_inputs();
        arr_idle = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_cfg_a", a_cfg, INIT4);
        chk("rst_cfg_b", b_cfg, INIT4);
        chk("rst_cfg_c", c_cfg, INIT3);
        chk("rst_flags_a", {a_rvld, a_err, a_upd, a_pend, a_locked}, 5'b0);
        chk("rst_rdat_a", a_rdat, 32'h0);
        #3 reset = 1'b1;

        // Read active reg 2, then confirm single-cycle rvld and held data
        cfg_rd = 1; cfg_addr = 2; tick();
        chk("rd2_rvld", a_rvld, 1'b1);
        chk("rd2_rdat", a_rdat, 32'h33333333);
        cfg_rd = 0; tick();
        chk("rd2_rvld_drop", a_rvld, 1'b0);
        chk("rd2_rdat_hold", a_rdat, 32'h33333333);

        // Byte-enabled write to shadow reg1
        cfg_wr = 1; cfg_addr = 1; cfg_dat = 32'hAABBCCDD; cfg_be = 4'b0101; tick();
        cfg_wr = 0; cfg_rd = 1; cfg_rd_shadow = 1;
        chk("wr1_active_unchanged", a_cfg, INIT4);
        tick();
        chk("wr1_shadow_rd", a_rdat, 32'h22BB22DD);
        cfg_rd_shadow = 0; tick();
        chk("wr1_active_rd", a_rdat, 32'h22222222);
        cfg_rd = 0;

        // Commit with array idle: G0 updates next cycle, G1 one later
        cfg_commit = 1; arr_idle = 1; tick();
        cfg_commit = 0;
        chk("cm_a_reg1", reg4(a_cfg, 1), 32'h22BB22DD);
        chk("cm_a_upd", a_upd, 1'b1);
        chk("cm_b_stale", b_cfg, INIT4);
        chk("cm_b_upd_early", b_upd, 1'b0);
        tick();
        chk("cm_a_upd_drop", a_upd, 1'b0);
        chk("cm_b_reg1", reg4(b_cfg, 1), 32'h22BB22DD);
        chk("cm_b_upd", b_upd, 1'b1);
        tick();
        chk("cm_b_upd_drop", b_upd, 1'b0);

        // Commit while busy: pending for five cycles, write reg0 meanwhile
        arr_idle = 0; cfg_commit = 1; tick();
        cfg_commit = 0;
        chk("pend_c1", a_pend, 1'b1);
        for (int i = 1; i < 5; i++) begin
            if (i == 2) begin
                cfg_wr = 1; cfg_addr = 0; cfg_dat = 32'hDEADBEEF; cfg_be = 4'hF;
            end
            if (i == 3) cfg_commit = 1;
            tick();
            cfg_wr = 0; cfg_commit = 0;
            chk("pend_hold", a_pend, 1'b1);
            chk("pend_cfg_stable", reg4(a_cfg, 0), 32'h11111111);
            chk("pend_no_err", a_err, 1'b0);
        end
        arr_idle = 1; tick();
        chk("pend_done", a_pend, 1'b0);
        chk("pend_reg0", reg4(a_cfg, 0), 32'hDEADBEEF);
        chk("pend_upd", a_upd, 1'b1);
        tick();
        chk("pend_upd_once", a_upd, 1'b0);
        chk("pend_b_reg0", reg4(b_cfg, 0), 32'hDEADBEEF);

        // Asynchronous reset while a commit is pending
        arr_idle = 0; cfg_commit = 1; tick();
        cfg_commit = 0;
        chk("arst_pend_b", b_pend, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_cfg_b", b_cfg, INIT4);
        chk("arst_cfg_a", a_cfg, INIT4);
        chk("arst_pend_b0", b_pend, 1'b0);
        #1 reset = 1'b1;

        // Lock: write and commit are rejected with an error each
        cfg_lock = 1; tick();
        cfg_lock = 0;
        chk("lock_set", a_locked, 1'b1);
        cfg_wr = 1; cfg_addr = 3; cfg_dat = 32'h12345678; cfg_be = 4'hF; tick();
        cfg_wr = 0;
        chk("lock_wr_err", a_err, 1'b1);
        tick();
        chk("lock_err_pulse", a_err, 1'b0);
        arr_idle = 1; cfg_commit = 1; tick();
        cfg_commit = 0;
        chk("lock_cm_err", a_err, 1'b1);
        chk("lock_cm_no_upd", a_upd, 1'b0);
        cfg_rd = 1; cfg_rd_shadow = 1; cfg_addr = 3; tick();
        cfg_rd = 0;
        chk("lock_shadow3", a_rdat, 32'h44444444);
        chk("lock_active3", reg4(a_cfg, 3), 32'h44444444);
        chk("lock_sticky", a_locked, 1'b1);
        reset = 1'b0; #1;
        chk("lock_cleared", a_locked, 1'b0);
        #1 reset = 1'b1;

        // NREGS=3: out-of-range write+read in one cycle -> one error pulse
        cfg_wr = 1; cfg_rd = 1; cfg_rd_shadow = 1; cfg_addr = 3;
        cfg_dat = 32'hCAFEF00D; cfg_be = 4'hF; tick();
        cfg_wr = 0; cfg_rd = 0;
        chk("oor_c_err", c_err, 1'b1);
        chk("oor_c_rvld", c_rvld, 1'b1);
        chk("oor_c_rdat", c_rdat, 32'h0);
        chk("oor_a_noerr", a_err, 1'b0);
        chk("oor_a_rdat_old", a_rdat, 32'h44444444);
        cfg_commit = 1; arr_idle = 1; tick();
        cfg_commit = 0;
        chk("oor_c_err_once", c_err, 1'b0);
        chk("oor_c_cfg", c_cfg, INIT3);
        chk("oor_a_reg3", reg4(a_cfg, 3), 32'hCAFEF00D);

        // Same-cycle read and write return the old value; be=0 is a no-op
        cfg_wr = 1; cfg_rd = 1; cfg_rd_shadow = 1; cfg_addr = 0;
        cfg_dat = 32'h0BADCAFE; cfg_be = 4'hF; tick();
        chk("rw_old_c", c_rdat, 32'h11111111);
        cfg_wr = 1; cfg_addr = 2; cfg_dat = 32'hFFFFFFFF; cfg_be = 4'h0; cfg_rd = 1; tick();
        chk("rw_new_c_prev", c_rdat, 32'h33333333);
        cfg_wr = 0; cfg_addr = 0; tick();
        chk("rw_new_c", c_rdat, 32'h0BADCAFE);
        cfg_addr = 2; tick();
        cfg_rd = 0;
        chk("be0_noop_c", c_rdat, 32'h33333333);
        chk("be0_no_err", c_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
